// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared state encoding and board defaults for the debouncer
//
// Holds the FSM state type used by button_debouncer and the default
// qualification window for the board clock (10 ms at 100 MHz).

package button_debouncer_pkg;

  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } deb_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_GLITCH_W        = 8;

endpackage

// File: rtl/button_debouncer_bit_synchronizer.sv
// rtl/button_debouncer_bit_synchronizer.sv - multi-flop synchroniser for one asynchronous bit
//
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous active-high reset, loads RESET_VAL into every stage
//   d    in   asynchronous input bit
//   q    out  synchronised bit (last stage of the chain)

module bit_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronise and debounce a raw button level, count rejected bounces
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   btn_in      in   raw asynchronous button/switch level
//   glitch_clr  in   synchronous clear of glitch_cnt (wins over a same-cycle increment)
//   btn_level   out  debounced level
//   busy        out  high while a candidate transition is being qualified
//   glitch_cnt  out  saturating count of rejected transitions

module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int GLITCH_W        = DEFAULT_GLITCH_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_in,
  input  logic                glitch_clr,
  output logic                btn_level,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Compare against the exact terminal value so a wider-than-needed counter
  // cannot stretch the qualification window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  deb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             reject;

  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync_q)
  );

  // A candidate is abandoned when the input returns to the stable level
  // before the window completes; this is what glitch_cnt counts.
  assign reject = ((state == S_CHK_HI) && !sync_q) ||
                  ((state == S_CHK_LO) &&  sync_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LO;
      cnt       <= '0;
      btn_level <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_LO: begin
          if (sync_q) begin
            state <= S_CHK_HI;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_CHK_HI: begin
          if (!sync_q) begin
            state <= S_LO;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= S_HI;
            btn_level <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HI: begin
          if (!sync_q) begin
            state <= S_CHK_LO;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_CHK_LO: begin
          if (sync_q) begin
            state <= S_HI;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= S_LO;
            btn_level <= 1'b0;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= S_LO;
          cnt       <= '0;
          btn_level <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (reject && (glitch_cnt != {GLITCH_W{1'b1}})) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer

module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       glitch_clr;
  logic       lvl0, busy0, lvl1, busy1;
  logic [3:0] gc0, gc1;

  always #5 clk = ~clk;

  button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .GLITCH_W(4)) dut0 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .glitch_clr(glitch_clr),
    .btn_level(lvl0), .busy(busy0), .glitch_cnt(gc0));

  button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .GLITCH_W(4)) dut1 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .glitch_clr(glitch_clr),
    .btn_level(lvl1), .busy(busy1), .glitch_cnt(gc1));

  int total = 0;
  int bad   = 0;

  // Reference model: a level flips once the synchronised input has disagreed
  // with it for DEB+1 consecutive samples; a disagreement run that ends early
  // is one rejected bounce.
  int m_deb [2] = '{4, 1};
  bit ms    [2];
  int m_run [2];
  bit m_lvl [2];
  int m_gc  [2];

  int ncyc = 0;
  bit prev0 = 1'b0;
  int last_toggle = -100;
  int rises0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ms[i] = 1'b0; m_run[i] = 0; m_lvl[i] = 1'b0; m_gc[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit sold;
    bit reject;
    if (rst) begin
      model_reset();
      return;
    end
    sold = ms[1];
    ms[1] = ms[0];
    ms[0] = btn_in;
    for (int i = 0; i < 2; i++) begin
      reject = 1'b0;
      if (sold != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == m_deb[i] + 1) begin
          m_lvl[i] = !m_lvl[i];
          m_run[i] = 0;
        end
      end else begin
        reject = (m_run[i] > 0);
        m_run[i] = 0;
      end
      if (glitch_clr) m_gc[i] = 0;
      else if (reject && m_gc[i] < 15) m_gc[i]++;
    end
  endtask

  task automatic cyc(input bit b, input bit c);
    btn_in = b;
    glitch_clr = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    ncyc++;
    chk("level0",  lvl0,  m_lvl[0]);
    chk("busy0",   busy0, m_run[0] > 0);
    chk("glitch0", gc0,   m_gc[0]);
    chk("level1",  lvl1,  m_lvl[1]);
    chk("busy1",   busy1, m_run[1] > 0);
    chk("glitch1", gc1,   m_gc[1]);
    if (lvl0 !== prev0) begin
      if (lvl0 === 1'b1) rises0++;
      chk("toggle_spacing", (ncyc - last_toggle) >= 5, 1);
      last_toggle = ncyc;
      prev0 = lvl0;
    end
  endtask

  task automatic measure(input bit b, output int n0, output int n1);
    n0 = -1;
    n1 = -1;
    for (int j = 1; j <= 20; j++) begin
      cyc(b, 1'b0);
      if (n0 < 0 && lvl0 === b) n0 = j;
      if (n1 < 0 && lvl1 === b) n1 = j;
    end
  endtask

  initial begin
    int n0, n1, r0;
    bit tgt;
    rst = 1'b1;
    btn_in = 1'b0;
    glitch_clr = 1'b0;
    model_reset();

    // Reset state
    cyc(0, 0);
    cyc(0, 0);
    rst = 1'b0;
    repeat (3) cyc(0, 0);

    // Clean press and release
    measure(1, n0, n1);
    chk("step_rise_lat0", n0, 7);
    chk("step_rise_lat1", n1, 4);
    measure(0, n0, n1);
    chk("step_fall_lat0", n0, 7);
    chk("step_fall_lat1", n1, 4);

    // Bounce 1,0,1,0 then hold high
    cyc(0, 1);
    cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
    measure(1, n0, n1);
    chk("bounce_rise_lat0", n0, 7);
    chk("bounce_glitches0", gc0, 2);

    // Release with a one-cycle spike during the check
    cyc(1, 1);
    cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(1, 0);
    measure(0, n0, n1);
    chk("spike_fall_lat0", n0, 7);
    chk("spike_glitches0", gc0, 1);

    // Saturation, then clear in the same cycle as a rejection
    cyc(0, 1);
    repeat (20) begin
      cyc(1, 0);
      cyc(0, 0);
    end
    cyc(0, 0); cyc(0, 0);
    chk("sat0", gc0, 15);
    chk("sat1", gc1, 15);
    cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(0, 1);
    chk("clr_priority0", gc0, 0);
    chk("clr_priority1", gc1, 0);

    // Asynchronous reset mid-check (dut1 is already high by then)
    cyc(0, 0); cyc(0, 0);
    repeat (4) cyc(1, 0);
    chk("busy_before_rst", busy0, 1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_level0", lvl0, 0);
    chk("rst_busy0",  busy0, 0);
    chk("rst_level1", lvl1, 0);
    chk("rst_busy1",  busy1, 0);
    cyc(1, 0);
    cyc(1, 0);
    rst = 1'b0;
    measure(1, n0, n1);
    chk("rst_release_lat0", n0, 7);
    chk("rst_release_lat1", n1, 4);

    // One clean pulse per bouncy press
    measure(0, n0, n1);
    r0 = rises0;
    cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(1, 0);
    repeat (12) cyc(1, 0);
    chk("one_pulse_per_press", rises0 - r0, 1);

    // Randomised bouncy traffic
    tgt = 1'b0;
    repeat (80) begin
      tgt = !tgt;
      repeat ($urandom_range(0, 3)) begin
        repeat ($urandom_range(1, 2)) cyc(tgt, 0);
        repeat ($urandom_range(1, 3)) cyc(!tgt, 0);
      end
      repeat ($urandom_range(0, 10)) cyc(tgt, ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
